t2b_decoder: RTL and testbench



---
 rtl/t2b_decoder.sv | 144 ++++++++++++++
 tb/tb_t2b_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/t2b_decoder.sv
// ---------------------------------------------------------------------------
// t2b_decoder : temporal-to-binary decoder.
//
// Measures the arrival phase of the first event on each of NUM_INPUTS
// temporal lines within a gamma cycle of GAMMA_CYCLE_WIDTH aclk periods.
// Once per gamma cycle it publishes the arrival phases as binary values.
//
// Ports:
//   aclk           in   clock, all state on posedge
//   grst           in   asynchronous active-high reset
//   sync           in   synchronous gamma-cycle realign (phase -> 0, no publish)
//   inputs         in   [NUM_INPUTS] temporal lines
//   phase          out  [SELECT_WIDTH] current gamma phase counter
//   binary_outputs out  [NUM_INPUTS*SELECT_WIDTH] per-line arrival phase,
//                       line i at [i*SELECT_WIDTH +: SELECT_WIDTH]
//   spike_valid    out  [NUM_INPUTS] line had an event in the published cycle
//   multi          out  [NUM_INPUTS] line had more than one event
//   out_valid      out  one-cycle strobe when published results update
//
// Build option:
//   T2B_FALLING_EN  lines idle high and the event is a falling edge;
//                   otherwise lines idle low and the event is a rising edge.
// ---------------------------------------------------------------------------
module t2b_decoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_INPUTS        = 4,
  parameter int SELECT_WIDTH      = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                               aclk,
  input  logic                               grst,
  input  logic                               sync,
  input  logic [NUM_INPUTS-1:0]              inputs,
  output logic [SELECT_WIDTH-1:0]            phase,
  output logic [NUM_INPUTS*SELECT_WIDTH-1:0] binary_outputs,
  output logic [NUM_INPUTS-1:0]              spike_valid,
  output logic [NUM_INPUTS-1:0]              multi,
  output logic                               out_valid
);

  localparam logic [SELECT_WIDTH-1:0] LAST_PHASE = SELECT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

`ifdef T2B_FALLING_EN
  localparam logic [NUM_INPUTS-1:0] IDLE_LEVEL = '1;
`else
  localparam logic [NUM_INPUTS-1:0] IDLE_LEVEL = '0;
`endif

  logic [SELECT_WIDTH-1:0]            phase_q, phase_d;
  logic [NUM_INPUTS-1:0]              in_prev_q;
  logic [NUM_INPUTS-1:0]              cap_vld_q, cap_vld_d;
  logic [NUM_INPUTS-1:0]              cap_multi_q, cap_multi_d;
  logic [NUM_INPUTS*SELECT_WIDTH-1:0] cap_val_q, cap_val_d;
  logic [NUM_INPUTS*SELECT_WIDTH-1:0] bin_q, bin_d;
  logic [NUM_INPUTS-1:0]              spike_q, spike_d;
  logic [NUM_INPUTS-1:0]              multi_q, multi_d;
  logic                               out_valid_q, out_valid_d;
  logic [NUM_INPUTS-1:0]              edge_w;
  logic                               boundary_w;

  always_comb begin
`ifdef T2B_FALLING_EN
    edge_w = ~inputs & in_prev_q;
`else
    edge_w = inputs & ~in_prev_q;
`endif
    boundary_w  = (phase_q == LAST_PHASE);

    phase_d     = boundary_w ? '0 : phase_q + 1'b1;
    cap_vld_d   = cap_vld_q;
    cap_multi_d = cap_multi_q;
    cap_val_d   = cap_val_q;
    bin_d       = bin_q;
    spike_d     = spike_q;
    multi_d     = multi_q;
    out_valid_d = 1'b0;

    if (sync) begin
      // Realign: abort the current cycle, drop any coincident edge.
      phase_d     = '0;
      cap_vld_d   = '0;
      cap_multi_d = '0;
      cap_val_d   = '0;
    end else if (boundary_w) begin
      // Publish; an edge arriving on the boundary itself counts at LAST_PHASE.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        spike_d[i] = cap_vld_q[i] | edge_w[i];
        multi_d[i] = cap_multi_q[i] | (cap_vld_q[i] & edge_w[i]);
        if (cap_vld_q[i])
          bin_d[i*SELECT_WIDTH +: SELECT_WIDTH] = cap_val_q[i*SELECT_WIDTH +: SELECT_WIDTH];
        else if (edge_w[i])
          bin_d[i*SELECT_WIDTH +: SELECT_WIDTH] = LAST_PHASE;
        else
          bin_d[i*SELECT_WIDTH +: SELECT_WIDTH] = '0;
      end
      out_valid_d = 1'b1;
      cap_vld_d   = '0;
      cap_multi_d = '0;
      cap_val_d   = '0;
    end else begin
      // First edge stores the phase; later edges only flag multi.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (edge_w[i]) begin
          if (cap_vld_q[i]) begin
            cap_multi_d[i] = 1'b1;
          end else begin
            cap_vld_d[i] = 1'b1;
            cap_val_d[i*SELECT_WIDTH +: SELECT_WIDTH] = phase_q;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      phase_q     <= '0;
      in_prev_q   <= IDLE_LEVEL;
      cap_vld_q   <= '0;
      cap_multi_q <= '0;
      cap_val_q   <= '0;
      bin_q       <= '0;
      spike_q     <= '0;
      multi_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      in_prev_q   <= inputs;
      cap_vld_q   <= cap_vld_d;
      cap_multi_q <= cap_multi_d;
      cap_val_q   <= cap_val_d;
      bin_q       <= bin_d;
      spike_q     <= spike_d;
      multi_q     <= multi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign phase          = phase_q;
  assign binary_outputs = bin_q;
  assign spike_valid    = spike_q;
  assign multi          = multi_q;
  assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_t2b_decoder.sv
// ---------------------------------------------------------------------------
// tb_t2b_decoder : directed self-checking bench for t2b_decoder
// (GAMMA_CYCLE_WIDTH=16, NUM_INPUTS=4). Stimulus is written as active-level
// events; with T2B_FALLING_EN the physical lines are inverted so the same
// sequence exercises falling-edge detection.
// ---------------------------------------------------------------------------
module tb_t2b_decoder;
  localparam int G  = 16;
  localparam int N  = 4;
  localparam int SW = 4;

`ifdef T2B_FALLING_EN
  localparam logic [N-1:0] POL = '1;
`else
  localparam logic [N-1:0] POL = '0;
`endif

  logic            aclk = 1'b0;
  logic            grst;
  logic            sync;
  logic [N-1:0]    lvl;
  logic [N-1:0]    inputs;
  logic [SW-1:0]   phase;
  logic [N*SW-1:0] binary_outputs;
  logic [N-1:0]    spike_valid;
  logic [N-1:0]    multi;
  logic            out_valid;

  int vectors = 0;
  int errors  = 0;
  int exp_phase = 0;

  assign inputs = lvl ^ POL;

  always #5 aclk = ~aclk;

  t2b_decoder #(.GAMMA_CYCLE_WIDTH(G), .NUM_INPUTS(N), .SELECT_WIDTH(SW)) dut (
    .aclk(aclk), .grst(grst), .sync(sync), .inputs(inputs),
    .phase(phase), .binary_outputs(binary_outputs), .spike_valid(spike_valid),
    .multi(multi), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [15:0] bin,
                         input logic [3:0] sp, input logic [3:0] mu);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".binary"}, {16'd0, binary_outputs}, {16'd0, bin});
    chk({tag, ".spike_valid"}, {28'd0, spike_valid}, {28'd0, sp});
    chk({tag, ".multi"}, {28'd0, multi}, {28'd0, mu});
  endtask

  // One clock; the phase model follows sync as sampled on the edge.
  task automatic tick();
    @(posedge aclk);
    if (sync) exp_phase = 0;
    else      exp_phase = (exp_phase + 1) % G;
    #1;
    chk("phase", {28'd0, phase}, exp_phase);
  endtask

  task automatic run_to(input int p);
    int n = 0;
    do begin
      tick();
      n++;
    end while (exp_phase != p && n < 40);
  endtask

  initial begin
    grst = 1'b1;
    sync = 1'b0;
    lvl  = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset.phase", {28'd0, phase}, 0);
    chk_out("reset", 1'b0, 16'h0000, 4'b0000, 4'b0000);
    grst = 1'b0;
    exp_phase = 0;

    // Line 0 event at phase 5; first publish 16 clocks after reset release.
    run_to(5);
    lvl[0] = 1'b1;
    tick();
    lvl[0] = 1'b0;
    run_to(0);
    chk_out("line0_p5", 1'b1, 16'h0005, 4'b0001, 4'b0000);
    tick();
    chk_out("hold", 1'b0, 16'h0005, 4'b0001, 4'b0000);

    // Cycle with no events.
    run_to(0);
    chk_out("empty", 1'b1, 16'h0000, 4'b0000, 4'b0000);

    // Line 1 pulses at phases 3 and 9.
    run_to(3);
    lvl[1] = 1'b1;
    tick();
    lvl[1] = 1'b0;
    run_to(9);
    lvl[1] = 1'b1;
    tick();
    lvl[1] = 1'b0;
    run_to(0);
    chk_out("line1_multi", 1'b1, 16'h0030, 4'b0010, 4'b0010);

    // Line 2 event on the boundary edge, then held across it.
    run_to(15);
    lvl[2] = 1'b1;
    tick();
    chk_out("line2_p15", 1'b1, 16'h0F00, 4'b0100, 4'b0000);
    run_to(0);
    chk_out("line2_held", 1'b1, 16'h0000, 4'b0000, 4'b0000);
    lvl[2] = 1'b0;

    // Line 3 event at phase 4, sync at phase 7 aborts the cycle.
    run_to(4);
    lvl[3] = 1'b1;
    tick();
    lvl[3] = 1'b0;
    run_to(7);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync.out_valid", {31'd0, out_valid}, 0);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("after_sync.out_valid", {31'd0, out_valid}, 0);
    end
    tick();
    chk_out("after_sync", 1'b1, 16'h0000, 4'b0000, 4'b0000);

    // Sync coincident with the boundary wins and drops the edge there.
    run_to(15);
    lvl[0] = 1'b1;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_boundary.out_valid", {31'd0, out_valid}, 0);
    lvl[0] = 1'b0;
    run_to(0);
    chk_out("sync_boundary", 1'b1, 16'h0000, 4'b0000, 4'b0000);

    // Nonzero published result, then reset mid-cycle after a capture.
    run_to(7);
    lvl[1] = 1'b1;
    tick();
    lvl[1] = 1'b0;
    run_to(0);
    chk_out("line1_p7", 1'b1, 16'h0070, 4'b0010, 4'b0000);
    run_to(2);
    lvl[0] = 1'b1;
    tick();
    lvl[0] = 1'b0;
    run_to(10);
    grst = 1'b1;
    #1;
    chk("grst.phase", {28'd0, phase}, 0);
    chk_out("grst", 1'b0, 16'h0000, 4'b0000, 4'b0000);
    @(posedge aclk);
    #1;
    grst = 1'b0;
    exp_phase = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("after_grst.out_valid", {31'd0, out_valid}, 0);
    end
    tick();
    chk_out("after_grst", 1'b1, 16'h0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
